// File: rtl/fp_recip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_recip_pkg
// Description : Shared types and constants for the iterative IEEE-754
//               reciprocal unit: FSM states, operand classes, flag indices
//               and the exponent-bias helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_recip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_INF  = 3'd1,
        CLS_NAN  = 3'd2,
        CLS_POW2 = 3'd3,
        CLS_NORM = 3'd4
    } class_t;

    // Bit positions inside the 4-bit flags vector {nan_in, dz, uf, nx}
    localparam int FLAG_NAN = 3;
    localparam int FLAG_DZ  = 2;
    localparam int FLAG_UF  = 1;
    localparam int FLAG_NX  = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage : fp_recip_pkg
`default_nettype wire

// File: rtl/fp_mant_restoring_div.sv
`default_nettype none
// ============================================================================
// Module      : fp_mant_restoring_div
// Description : Radix-2 restoring divider computing 2.0 / D for a normalised
//               mantissa D = 1.f, one quotient bit per cycle over FRAC_W+2
//               cycles. Quotient is {1, frac, guard}; sticky = remainder != 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mant_restoring_div #(
    parameter int FRAC_W = 52
) (
    input  logic              clk,
    input  logic              rset,
    input  logic              start,
    input  logic [FRAC_W:0]   divisor,
    output logic [FRAC_W+1:0] quotient,
    output logic              sticky,
    output logic              busy,
    output logic              done
);

    localparam int c_STEPS = FRAC_W + 2;
    localparam int c_CNT_W = $clog2(c_STEPS + 1);
    // 2.0 expressed in the divisor's scaling (LSB weight 2^-FRAC_W)
    localparam logic [FRAC_W+2:0] c_TWO = {2'b01, {(FRAC_W+1){1'b0}}};

    logic [FRAC_W+2:0] r_rem;
    logic [FRAC_W+1:0] r_quo;
    logic [FRAC_W:0]   r_div;
    logic [c_CNT_W-1:0] r_cnt;
    logic              r_busy;

    logic              w_ge;
    logic [FRAC_W+2:0] w_rem_sub;

    // Trial subtraction; the remainder is restored by simply not taking it
    always_comb begin
        w_ge      = (r_rem >= {2'b00, r_div});
        w_rem_sub = w_ge ? (r_rem - {2'b00, r_div}) : r_rem;
    end

    // Iteration registers: load on start, then one quotient bit per cycle
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= c_TWO;
            r_quo  <= '0;
            r_div  <= divisor;
            r_cnt  <= c_CNT_W'(c_STEPS);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            // remainder after subtraction is < D, so the shifted value fits
            r_rem <= {w_rem_sub[FRAC_W+1:0], 1'b0};
            r_quo <= {r_quo[FRAC_W:0], w_ge};
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (r_cnt == c_CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign quotient = r_quo;
    assign sticky   = |r_rem;
    assign busy     = r_busy;
    // high during the cycle whose closing edge performs the final iteration
    assign done     = r_busy && (r_cnt == c_CNT_W'(1));

endmodule : fp_mant_restoring_div
`default_nettype wire

// File: rtl/fp_reciprocal_iter.sv
`default_nettype none
// ============================================================================
// Module      : fp_reciprocal_iter
// Description : Parametrised IEEE-754 reciprocal (1/x) with valid/ready
//               handshakes. Specials resolve in one cycle; ordinary operands
//               go through an iterative restoring mantissa divider followed
//               by round-to-nearest-even.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_reciprocal_iter
    import fp_recip_pkg::*;
#(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    localparam int W     = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rset,
    input  logic [W-1:0] rcprcl_input,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] rcprcl_output,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   flags
);

    localparam int BIAS = fp_bias(EXP_W);
    localparam logic [EXP_W+1:0] c_TWO_BIAS = (EXP_W+2)'(2 * BIAS);
    localparam logic [EXP_W+1:0] c_ONE      = (EXP_W+2)'(1);
    localparam logic [W-1:0]     c_QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    state_t r_state, w_state_nxt;
    class_t w_cls;

    logic                r_sign;
    logic [EXP_W-1:0]    r_exp_in;
    logic [W-1:0]        r_out;
    logic [3:0]          r_flags;

    logic                w_sign;
    logic [EXP_W-1:0]    w_exp_f;
    logic [FRAC_W-1:0]   w_frac_f;
    logic                w_accept;
    logic                w_start;
    logic [EXP_W+1:0]    w_pow2_exp;

    logic [FRAC_W+1:0]   w_quo;
    logic                w_sticky;
    logic                w_div_busy;
    logic                w_div_done;

    logic [FRAC_W-1:0]   w_frac_q;
    logic                w_guard;
    logic                w_rnd_up;
    logic [FRAC_W:0]     w_frac_sum;
    logic [EXP_W+1:0]    w_exp_rnd;
    logic                w_uf;
    logic [W-1:0]        w_rnd_out;
    logic [3:0]          w_rnd_flags;

    assign w_sign     = rcprcl_input[W-1];
    assign w_exp_f    = rcprcl_input[W-2:FRAC_W];
    assign w_frac_f   = rcprcl_input[FRAC_W-1:0];
    assign in_ready   = (r_state == IDLE) && !w_div_busy;
    assign w_accept   = in_valid && in_ready;
    assign w_start    = w_accept && (w_cls == CLS_NORM);
    // exact reciprocal exponent of a power of two; zero means it underflows
    assign w_pow2_exp = c_TWO_BIAS - {2'b00, w_exp_f};

    // Operand classification; subnormals are flushed and treated as zero
    always_comb begin
        w_cls = CLS_NORM;
        if (w_exp_f == '1) begin
            w_cls = (w_frac_f != '0) ? CLS_NAN : CLS_INF;
        end else if (w_exp_f == '0) begin
            w_cls = CLS_ZERO;
        end else if (w_frac_f == '0) begin
            w_cls = CLS_POW2;
        end
    end

    fp_mant_restoring_div #(
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk      (clk),
        .rset     (rset),
        .start    (w_start),
        .divisor  ({1'b1, w_frac_f}),
        .quotient (w_quo),
        .sticky   (w_sticky),
        .busy     (w_div_busy),
        .done     (w_div_done)
    );

    // RNE on {1, frac, guard} plus sticky; exponent is 2*BIAS-e-1 (+carry)
    always_comb begin
        w_frac_q    = w_quo[FRAC_W:1];
        w_guard     = w_quo[0];
        w_rnd_up    = w_guard && (w_sticky || w_frac_q[0]);
        w_frac_sum  = {1'b0, w_frac_q} + {{FRAC_W{1'b0}}, w_rnd_up};
        w_exp_rnd   = c_TWO_BIAS - {2'b00, r_exp_in} - c_ONE
                    + {{(EXP_W+1){1'b0}}, w_frac_sum[FRAC_W]};
        w_uf        = w_exp_rnd[EXP_W+1] || (w_exp_rnd == '0);
        w_rnd_flags = '0;
        if (w_uf) begin
            w_rnd_out            = {r_sign, {(W-1){1'b0}}};
            w_rnd_flags[FLAG_UF] = 1'b1;
            w_rnd_flags[FLAG_NX] = 1'b1;
        end else begin
            // on carry-out the low FRAC_W bits of the sum are already zero
            w_rnd_out            = {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_sum[FRAC_W-1:0]};
            w_rnd_flags[FLAG_NX] = w_guard || w_sticky;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (w_cls == CLS_NORM) ? ITER : DONE;
            ITER:    if (w_div_done) w_state_nxt = ROUND;
            ROUND:   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result/flag registers: specials written at accept, divisions at ROUND
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_sign   <= 1'b0;
            r_exp_in <= '0;
            r_out    <= '0;
            r_flags  <= '0;
        end else if (w_accept) begin
            r_sign   <= w_sign;
            r_exp_in <= w_exp_f;
            r_flags  <= '0;
            case (w_cls)
                CLS_NAN: begin
                    r_out             <= c_QNAN;
                    r_flags[FLAG_NAN] <= 1'b1;
                end
                CLS_ZERO: begin
                    r_out            <= {w_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    r_flags[FLAG_DZ] <= 1'b1;
                end
                CLS_INF: begin
                    r_out <= {w_sign, {(W-1){1'b0}}};
                end
                CLS_POW2: begin
                    if (w_pow2_exp == '0) begin
                        r_out            <= {w_sign, {(W-1){1'b0}}};
                        r_flags[FLAG_UF] <= 1'b1;
                    end else begin
                        r_out <= {w_sign, w_pow2_exp[EXP_W-1:0], {FRAC_W{1'b0}}};
                    end
                end
                default: begin
                    r_out <= '0;
                end
            endcase
        end else if (r_state == ROUND) begin
            r_out   <= w_rnd_out;
            r_flags <= w_rnd_flags;
        end
    end

    assign out_valid     = (r_state == DONE);
    assign rcprcl_output = r_out;
    assign flags         = r_flags;

endmodule : fp_reciprocal_iter
`default_nettype wire

// File: tb/tb_fp_reciprocal_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_reciprocal_iter
// Description : Self-checking bench for fp_reciprocal_iter in double and
//               single precision, with a behavioural reciprocal model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_reciprocal_iter;

    logic clk = 1'b0;
    logic rset = 1'b0;
    always #5 clk = ~clk;

    // double-precision instance (index 0)
    logic [63:0] in_d = '0, out_d;
    logic        vin_d = 1'b0, rdy_d, ov_d, ordy_d = 1'b0;
    logic [3:0]  fl_d;
    // single-precision instance (index 1)
    logic [31:0] in_s = '0, out_s;
    logic        vin_s = 1'b0, rdy_s, ov_s, ordy_s = 1'b0;
    logic [3:0]  fl_s;

    fp_reciprocal_iter dut_d (
        .clk(clk), .rset(rset), .rcprcl_input(in_d), .in_valid(vin_d), .in_ready(rdy_d),
        .rcprcl_output(out_d), .out_valid(ov_d), .out_ready(ordy_d), .flags(fl_d));

    fp_reciprocal_iter #(.EXP_W(8), .FRAC_W(23)) dut_s (
        .clk(clk), .rset(rset), .rcprcl_input(in_s), .in_valid(vin_s), .in_ready(rdy_s),
        .rcprcl_output(out_s), .out_valid(ov_s), .out_ready(ordy_s), .flags(fl_s));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_res [2];
    logic [3:0]  exp_fl  [2];
    int          exp_lat [2];
    int          acc     [2];
    bit          pend    [2] = '{1'b0, 1'b0};
    bit          seen    [2] = '{1'b0, 1'b0};

    // Reference: 1/x from the format rules, using wide integer division
    function automatic logic [67:0] model(input logic [63:0] x, input int ew, input int fw);
        logic [127:0] xx, emax, fmask, f, d, num, q, r, mant, sgn, res;
        int e, bias, ee;
        logic guard, sticky, inexact;
        logic [3:0] fl;
        xx    = {64'b0, x};
        fmask = (128'd1 << fw) - 128'd1;
        emax  = (128'd1 << ew) - 128'd1;
        sgn   = {127'b0, x[ew+fw]} << (ew + fw);
        e     = int'((xx >> fw) & emax);
        f     = xx & fmask;
        bias  = (1 << (ew - 1)) - 1;
        res   = '0;
        fl    = '0;
        if (e == int'(emax)) begin
            if (f != 0) begin
                res = (emax << fw) | (128'd1 << (fw - 1));
                fl  = 4'b1000;
            end else begin
                res = sgn;
            end
        end else if (e == 0) begin
            res = sgn | (emax << fw);
            fl  = 4'b0100;
        end else if (f == 0) begin
            ee = 2 * bias - e;
            if (ee <= 0) begin
                res = sgn;
                fl  = 4'b0010;
            end else begin
                res = sgn | (128'(ee) << fw);
            end
        end else begin
            d       = (128'd1 << fw) | f;
            num     = 128'd1 << (2 * fw + 2);
            q       = num / d;
            r       = num % d;
            mant    = q >> 1;
            guard   = q[0];
            sticky  = (r != 0);
            inexact = guard | sticky;
            if (guard && (sticky || mant[0])) mant = mant + 128'd1;
            ee = 2 * bias - e - 1;
            if ((mant >> (fw + 1)) != 0) begin
                ee   = ee + 1;
                mant = mant >> 1;
            end
            if (ee <= 0) begin
                res = sgn;
                fl  = 4'b0011;
            end else begin
                res = sgn | (128'(ee) << fw) | (mant & fmask);
                fl  = {3'b000, inexact};
            end
        end
        return {fl, res[63:0]};
    endfunction

    function automatic logic [63:0] rand_op(input int ew, input int fw);
        logic [127:0] f, e;
        logic s;
        int emax_i, kind;
        emax_i = (1 << ew) - 1;
        f    = {64'b0, $urandom, $urandom} & ((128'd1 << fw) - 128'd1);
        s    = 1'($urandom);
        kind = int'($urandom_range(0, 9));
        case (kind)
            0: e = 128'd0;
            1: e = 128'(emax_i);
            2: begin e = 128'($urandom_range(1, emax_i - 1)); f = '0; end
            3: e = 128'(emax_i - 1 - int'($urandom_range(0, 2)));
            4: begin e = 128'($urandom_range(1, emax_i - 1)); f = 128'($urandom_range(1, 3)); end
            default: e = 128'($urandom_range(1, emax_i - 1));
        endcase
        return 64'(({127'b0, s} << (ew + fw)) | (e << fw) | f);
    endfunction

    // Compare process: every cycle a result is presented, check it
    always @(negedge clk) begin
        if (rset) begin
            for (int k = 0; k < 2; k++) begin
                logic        ov, rdy;
                logic [63:0] o;
                logic [3:0]  fl;
                ov  = (k == 0) ? ov_d : ov_s;
                rdy = (k == 0) ? rdy_d : rdy_s;
                o   = (k == 0) ? out_d : {32'b0, out_s};
                fl  = (k == 0) ? fl_d : fl_s;
                if (ov) begin
                    checks++;
                    if (!pend[k]) begin
                        errors++;
                        $display("FAIL spurious_valid dut%0d out=%h flags=%b", k, o, fl);
                    end else begin
                        if (o !== exp_res[k] || fl !== exp_fl[k]) begin
                            errors++;
                            $display("FAIL result dut%0d got %h/%b expected %h/%b", k, o, fl, exp_res[k], exp_fl[k]);
                        end
                        if (!seen[k]) begin
                            checks++;
                            seen[k] = 1'b1;
                            if (cyc - acc[k] + 1 != exp_lat[k]) begin
                                errors++;
                                $display("FAIL latency dut%0d got %0d expected %0d", k, cyc - acc[k] + 1, exp_lat[k]);
                            end
                        end
                        checks++;
                        if (rdy !== 1'b0) begin
                            errors++;
                            $display("FAIL in_ready_while_valid dut%0d got %b expected 0", k, rdy);
                        end
                    end
                end
            end
        end
    end

    task automatic set_in(input int k, input logic [63:0] x, input logic v);
        if (k == 0) begin in_d = x; vin_d = v; end
        else begin in_s = x[31:0]; vin_s = v; end
    endtask

    task automatic run_op(input int k, input logic [63:0] x, input bit use_lit,
                          input logic [63:0] lit_res, input logic [3:0] lit_fl, input int hold);
        int ew, fw, n, e;
        logic [63:0] fmask;
        logic [67:0] m;
        ew = (k == 0) ? 11 : 8;
        fw = (k == 0) ? 52 : 23;
        m  = model(x, ew, fw);
        if (use_lit) begin
            checks++;
            if (m !== {lit_fl, lit_res}) begin
                errors++;
                $display("FAIL model_pin x=%h got %h/%b expected %h/%b", x, m[63:0], m[67:64], lit_res, lit_fl);
            end
        end
        fmask = (64'd1 << fw) - 64'd1;
        e     = int'((x >> fw) & ((64'd1 << ew) - 64'd1));
        n = 0;
        while (((k == 0) ? rdy_d : rdy_s) !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL in_ready_timeout dut%0d got 0 expected 1", k);
                return;
            end
        end
        exp_res[k] = m[63:0];
        exp_fl[k]  = m[67:64];
        exp_lat[k] = (e != 0 && e != (1 << ew) - 1 && (x & fmask) != 0) ? fw + 4 : 1;
        seen[k]    = 1'b0;
        pend[k]    = 1'b1;
        set_in(k, x, 1'b1);
        @(posedge clk);
        #1;
        acc[k] = cyc;
        set_in(k, x, 1'b0);
        n = 0;
        while (((k == 0) ? ov_d : ov_s) !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                errors++;
                $display("FAIL out_valid_timeout dut%0d got 0 expected 1", k);
                pend[k] = 1'b0;
                return;
            end
        end
        repeat (hold) @(negedge clk);
        if (k == 0) ordy_d = 1'b1; else ordy_s = 1'b1;
        @(posedge clk);
        #1;
        pend[k] = 1'b0;
        if (k == 0) ordy_d = 1'b0; else ordy_s = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {62'b0, rdy_d, rdy_s}, 64'd3);
        chk("reset_out_valid", {62'b0, ov_d, ov_s}, 64'd0);
        chk("reset_output", out_d, 64'd0);
        chk("reset_flags", {56'b0, fl_d, fl_s}, 64'd0);
        rset = 1'b1;
        @(negedge clk);

        // Directed double-precision vectors with literal expectations
        run_op(0, 64'h4000000000000000, 1, 64'h3FE0000000000000, 4'b0000, 0);
        run_op(0, 64'h4008000000000000, 1, 64'h3FD5555555555555, 4'b0001, 1);
        run_op(0, 64'h0000000000000000, 1, 64'h7FF0000000000000, 4'b0100, 0);
        run_op(0, 64'h8000000000000000, 1, 64'hFFF0000000000000, 4'b0100, 2);
        run_op(0, 64'h7FF0000000000000, 1, 64'h0000000000000000, 4'b0000, 0);
        run_op(0, 64'h7FF0000000000001, 1, 64'h7FF8000000000000, 4'b1000, 0);
        run_op(0, 64'h7FE0000000000000, 1, 64'h0000000000000000, 4'b0010, 0);
        run_op(0, 64'hC000000000000000, 1, 64'hBFE0000000000000, 4'b0000, 0);
        run_op(0, 64'h000FFFFFFFFFFFFF, 1, 64'h7FF0000000000000, 4'b0100, 0);

        // Single precision, result held for 10 cycles
        run_op(1, 64'h0000000040400000, 1, 64'h000000003EAAAAAB, 4'b0001, 10);
        run_op(1, 64'h00000000BF800000, 1, 64'h00000000BF800000, 4'b0000, 0);

        // Asynchronous reset in the middle of an iteration
        @(negedge clk);
        in_d = 64'h4008000000000000;
        vin_d = 1'b1;
        @(posedge clk);
        #1 vin_d = 1'b0;
        repeat (20) @(posedge clk);
        #3 rset = 1'b0;
        #1;
        chk("midreset_out_valid", {63'b0, ov_d}, 64'd0);
        chk("midreset_in_ready", {63'b0, rdy_d}, 64'd1);
        chk("midreset_output", out_d, 64'd0);
        @(negedge clk);
        rset = 1'b1;
        run_op(0, 64'h4008000000000000, 1, 64'h3FD5555555555555, 4'b0001, 0);

        // Randomised operands
        for (int i = 0; i < 16; i++) begin
            run_op(0, rand_op(11, 52), 0, '0, '0, int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 60; i++) begin
            run_op(1, rand_op(8, 23), 0, '0, '0, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fp_reciprocal_iter
`default_nettype wire
